// File: rtl/cache_controller.sv
// Direct-mapped write-through cache between the CPU load/store port and 1K-word main memory.
// Define WRITE_ALLOCATE_EN to make store misses fill the line before writing through.
module cache_controller #(
  parameter int unsigned INDEX_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [9:0]    cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [9:0]    mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [127:0]  mem_block,
  input  logic          mem_ready
);

  localparam int unsigned TAG_W = 8 - INDEX_W;
  localparam int unsigned LINES = 1 << INDEX_W;

`ifdef WRITE_ALLOCATE_EN
  localparam bit WR_ALLOC = 1'b1;
`else
  localparam bit WR_ALLOC = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_MISS = 2'd1,
    S_WRITE_MEM = 2'd2,
    S_RELEASE   = 2'd3
  } state_e;

  state_e             state_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               wdone_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][4];

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         offset;
  logic               hit;
  logic               wr_req;
  logic               rd_miss;

  assign index  = cpu_addr[INDEX_W+1:2];
  assign tag    = cpu_addr[9:INDEX_W+2];
  assign offset = cpu_addr[1:0];

  // wdone_q marks the IDLE cycle in which a held store is retired after its memory write.
  always_comb begin
    hit     = 1'b0;
    wr_req  = 1'b0;
    rd_miss = 1'b0;
    hit     = valid_q[index] && (tag_q[index] == tag);
    wr_req  = cpu_write && !wdone_q;
    rd_miss = cpu_read && !cpu_write && !hit;
    stall   = (state_q != S_IDLE) || wr_req || rd_miss;
  end

  assign cpu_rdata = data_q[index][offset];
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wdone_q     <= 1'b0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wdone_q <= 1'b0;
          if (wr_req) begin
            if (hit || !WR_ALLOC) begin
              state_q     <= S_WRITE_MEM;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= S_READ_MISS;
              mem_read_q <= 1'b1;
            end
          end else if (rd_miss) begin
            state_q    <= S_READ_MISS;
            mem_read_q <= 1'b1;
          end
        end
        S_READ_MISS: begin
          if (mem_ready) begin
            state_q        <= S_RELEASE;
            mem_read_q     <= 1'b0;
            valid_q[index] <= 1'b1;
          end
        end
        S_WRITE_MEM: begin
          if (mem_ready) begin
            state_q     <= S_RELEASE;
            mem_write_q <= 1'b0;
            wdone_q     <= 1'b1;
          end
        end
        S_RELEASE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (state_q == S_READ_MISS && mem_ready) begin
      tag_q[index]     <= tag;
      data_q[index][0] <= mem_block[31:0];
      data_q[index][1] <= mem_block[63:32];
      data_q[index][2] <= mem_block[95:64];
      data_q[index][3] <= mem_block[127:96];
    end else if (state_q == S_IDLE && wr_req && hit) begin
      data_q[index][offset] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, reset-abort sequence, and random ops vs a reference model.
`timescale 1ns/1ps
module tb_cache_controller;

  localparam int unsigned INDEX_W = 5;
  localparam int unsigned LINES   = 1 << INDEX_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_read, cpu_write;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         stall, mem_read, mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_block;
  logic         mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int both_seen = 0;

  cache_controller #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_block(mem_block), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Main memory: mem_ready pulses after lat edges of a held request.
  logic [31:0] mem [1024];
  int unsigned lat = 4;
  int unsigned cnt = 0;
  assign mem_block = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                      mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};
  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      cnt       <= cnt + 1;
      mem_ready <= ((cnt + 1) == lat);
      if (mem_write && mem_ready) mem[mem_addr] <= mem_wdata;
    end else begin
      cnt       <= 0;
      mem_ready <= 1'b0;
    end
  end

  // Reference model: expected memory image plus per-line valid/tag.
  logic [31:0] ref_mem [1024];
  bit          rv [LINES];
  int unsigned rt [LINES];

  function automatic void ref_op(input bit wr, input logic [9:0] a, input logic [31:0] wd,
                                 output int exp_st, output logic [31:0] exp_d);
    int unsigned idx  = (int'(a) / 4) % LINES;
    int unsigned tg   = int'(a) / (4 * LINES);
    bit          hit  = rv[idx] && (rt[idx] == tg);
    int          cost = int'(lat) + 3;
    exp_d = ref_mem[a];
    if (!wr) begin
      exp_st  = hit ? 0 : cost;
      rv[idx] = 1'b1;
      rt[idx] = tg;
    end else begin
      exp_st = cost;
`ifdef WRITE_ALLOCATE_EN
      if (!hit) begin
        exp_st  = 2 * cost;
        rv[idx] = 1'b1;
        rt[idx] = tg;
      end
`endif
      ref_mem[a] = wd;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; count stalled cycles and memory request cycles.
  task automatic do_op(input bit wr, input logic [9:0] a, input logic [31:0] wd,
                       output int st, output int rdc, output int wrc, output logic [31:0] rd);
    st = 0; rdc = 0; wrc = 0; rd = '0;
    cpu_read = !wr; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (mem_read && mem_write) both_seen++;
      if (!stall) begin
        rd = cpu_rdata;
        break;
      end
      st++;
      if (mem_read) rdc++;
      if (mem_write) wrc++;
      @(negedge clk);
    end
    check("op_completes", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          st;
    int          rdc;
    int          wrc;
    bit          chk;
    logic [31:0] rdata;
  } vec_t;

`ifdef WRITE_ALLOCATE_EN
  localparam int SM_ST = 14, SM_RD = 5, LM_ST = 0, LM_RD = 0;
`else
  localparam int SM_ST = 7,  SM_RD = 0, LM_ST = 7, LM_RD = 5;
`endif

  vec_t vecs [11];

  initial begin
    int          st, rdc, wrc, est, bad;
    logic [31:0] rd, ed;
    logic [9:0]  a;
    logic [31:0] wd;
    bit          wr;

    vecs[0]  = '{1'b0, 10'h004, 32'h0,         7,     5,     0, 1'b1, 32'hA5A5_0004};
    vecs[1]  = '{1'b0, 10'h005, 32'h0,         0,     0,     0, 1'b1, 32'hA5A5_0005};
    vecs[2]  = '{1'b1, 10'h004, 32'hDEAD_BEEF, 7,     0,     5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 10'h004, 32'h0,         0,     0,     0, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 10'h100, 32'h0000_1234, SM_ST, SM_RD, 5, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 10'h100, 32'h0,         LM_ST, LM_RD, 0, 1'b1, 32'h0000_1234};
    vecs[6]  = '{1'b0, 10'h004, 32'h0,         0,     0,     0, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 10'h084, 32'h0,         7,     5,     0, 1'b1, 32'hA5A5_0084};
    vecs[8]  = '{1'b0, 10'h004, 32'h0,         7,     5,     0, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 10'h200, 32'h0000_0055, SM_ST, SM_RD, 5, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 10'h201, 32'h0,         LM_ST, LM_RD, 0, 1'b1, 32'hA5A5_0201};

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    for (int i = 0; i < int'(LINES); i++) begin
      rv[i] = 1'b0;
      rt[i] = 0;
    end

    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);
    cpu_read = 1'b1;
    #1;
    check("rst_stall_load_invalid", 32'(stall), 32'd1);
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    lat = 4;
    for (int i = 0; i < 11; i++) begin
      ref_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, est, ed);
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rdc, wrc, rd);
      check($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].st));
      check($sformatf("vec%0d_mem_read_cycles", i), 32'(rdc), 32'(vecs[i].rdc));
      check($sformatf("vec%0d_mem_write_cycles", i), 32'(wrc), 32'(vecs[i].wrc));
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end
    check("mem4_written", mem[4], 32'hDEAD_BEEF);
    check("mem100_written", mem[10'h100], 32'h0000_1234);

    // Reset in the third mem_read cycle of a miss
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h300;
    rdc = 0;
    for (int i = 0; i < 50 && rdc < 3; i++) begin
      #1;
      if (mem_read) rdc++;
      if (rdc < 3) @(negedge clk);
    end
    check("midrst_reached_cycle3", 32'(rdc), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_read_drops", 32'(mem_read), 32'd0);
    check("midrst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b0; cpu_read = 1'b0;
    for (int i = 0; i < int'(LINES); i++) rv[i] = 1'b0;
    @(negedge clk);
    ref_op(1'b0, 10'h300, 32'h0, est, ed);
    do_op(1'b0, 10'h300, 32'h0, st, rdc, wrc, rd);
    check("post_rst_300_stalls", 32'(st), 32'd7);
    check("post_rst_300_rdata", rd, 32'hA5A5_0300);
    ref_op(1'b0, 10'h004, 32'h0, est, ed);
    do_op(1'b0, 10'h004, 32'h0, st, rdc, wrc, rd);
    check("post_rst_004_stalls", 32'(st), 32'd7);
    check("post_rst_004_rdata", rd, 32'hDEAD_BEEF);

    // Random ops with random memory latency
    for (int n = 0; n < 80; n++) begin
      lat = $urandom_range(1, 6);
      wr  = ($urandom_range(0, 2) == 0);
      a   = 10'(($urandom_range(0, 3) << 7) | $urandom_range(0, 15));
      wd  = $urandom;
      ref_op(wr, a, wd, est, ed);
      do_op(wr, a, wd, st, rdc, wrc, rd);
      check($sformatf("rnd%0d_stalls_addr%h", n, a), 32'(st), 32'(est));
      if (!wr) check($sformatf("rnd%0d_rdata_addr%h", n, a), rd, ed);
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory_image_mismatches", 32'(bad), 32'd0);
    check("mem_read_and_write_both_high", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
